// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu -- MEM-stage load/store unit for an RV64I pipeline.
//
// Purpose:
//   Turns a MEM-stage load or store into a single-beat request on a simple
//   grant/read-valid data bus. It aligns store data and byte strobes to the
//   64-bit bus lane, extracts and extends load data, and stalls upstream
//   stages until the access completes. Faulting accesses (misaligned or
//   illegal funct3) are flagged combinationally and never reach the bus.
//   Non-memory ops pass through with zero latency.
//
// State table:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no access in flight; accepts a new access, pass-through path
//   ST_REQ  | bus request held with latched addr/data/strobes until granted
//   ST_WAIT | load granted, waiting for read-valid; grant ignored
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   valid_i                   MEM-stage instruction is live
//   Mem_REn_i, Mem_WEn_i      load / store (both high = load)
//   funct3_i                  RV64I size/sign code
//   addr_i                    byte address from the ALU
//   store_data_i              unshifted rs2 value
//   alu_result_i              write-back value for non-memory ops
//   WB_Data_o                 value captured by MEMWB
//   Mem_REn_o                 valid_i & Mem_REn_i
//   stall_o                   freeze upstream / hold MEMWB inputs
//   err_o                     misaligned access or illegal funct3
//   dmem_req_o, dmem_we_o     bus request and write flag
//   dmem_addr_o               dword-aligned bus address
//   dmem_wdata_o, dmem_wstrb_o lane-aligned store data and byte strobes
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i  grant, read-valid, read data
// -----------------------------------------------------------------------------
module mem_lsu #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  Mem_REn_i,
  input  logic                  Mem_WEn_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  output logic [DATA_WIDTH-1:0] WB_Data_o,
  output logic                  Mem_REn_o,
  output logic                  stall_o,
  output logic                  err_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [7:0]            dmem_wstrb_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched request; only these are used once the FSM leaves ST_IDLE.
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [7:0]            r_wstrb;

  // ---------------------------------------------------------------------------
  // Decode of the live (unlatched) request
  // ---------------------------------------------------------------------------
  logic                  w_mem_op;
  logic                  w_is_load;
  logic                  w_illegal;
  logic                  w_misalign;
  logic                  w_fault;
  logic                  w_start;
  logic [2:0]            w_byte_off;
  logic [5:0]            w_wshamt;
  logic [7:0]            w_wstrb_base;
  logic [DATA_WIDTH-1:0] w_wdata_lane;
  logic [7:0]            w_wstrb_lane;

  assign w_mem_op   = valid_i & (Mem_REn_i | Mem_WEn_i);
  // Both enables high is treated as a load.
  assign w_is_load  = Mem_REn_i;
  assign w_illegal  = w_is_load ? (funct3_i == 3'b111) : funct3_i[2];
  assign w_byte_off = addr_i[2:0];
  assign w_wshamt   = {w_byte_off, 3'b000};

  always_comb begin
    w_misalign   = 1'b0;
    w_wstrb_base = 8'h01;
    case (funct3_i[1:0])
      2'b00: begin
        w_misalign   = 1'b0;
        w_wstrb_base = 8'h01;
      end
      2'b01: begin
        w_misalign   = addr_i[0];
        w_wstrb_base = 8'h03;
      end
      2'b10: begin
        w_misalign   = |addr_i[1:0];
        w_wstrb_base = 8'h0F;
      end
      default: begin
        w_misalign   = |addr_i[2:0];
        w_wstrb_base = 8'hFF;
      end
    endcase
  end

  assign w_fault      = w_mem_op & (w_illegal | w_misalign);
  assign w_start      = (r_state == ST_IDLE) & w_mem_op & ~w_fault;
  assign w_wdata_lane = store_data_i << w_wshamt;
  assign w_wstrb_lane = w_wstrb_base << w_byte_off;

  // ---------------------------------------------------------------------------
  // Request latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else if (w_start) begin
      r_addr   <= addr_i;
      r_funct3 <= funct3_i;
      r_we     <= ~w_is_load;
      // Loads write no bytes, so their strobes and data stay quiet on the bus.
      r_wdata  <= w_is_load ? '0 : w_wdata_lane;
      r_wstrb  <= w_is_load ? 8'h00 : w_wstrb_lane;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data extraction from the latched address and size code
  // ---------------------------------------------------------------------------
  logic [5:0]            w_rshamt;
  logic [DATA_WIDTH-1:0] w_rshift;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_rshamt = {r_addr[2:0], 3'b000};
  assign w_rshift = dmem_rdata_i >> w_rshamt;

  always_comb begin
    w_load_data = dmem_rdata_i;
    case (r_funct3)
      3'b000:  w_load_data = {{(DATA_WIDTH-8){w_rshift[7]}},   w_rshift[7:0]};
      3'b001:  w_load_data = {{(DATA_WIDTH-16){w_rshift[15]}}, w_rshift[15:0]};
      3'b010:  w_load_data = {{(DATA_WIDTH-32){w_rshift[31]}}, w_rshift[31:0]};
      3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}},          w_rshift[7:0]};
      3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}},         w_rshift[15:0]};
      3'b110:  w_load_data = {{(DATA_WIDTH-32){1'b0}},         w_rshift[31:0]};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  logic                  w_stall;
  logic                  w_err;
  logic                  w_req;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_wb;

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_err       = 1'b0;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_wb        = alu_result_i;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          w_wb = '0;
          if (w_fault) begin
            w_err = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        w_req   = 1'b1;
        w_we    = r_we;
        w_stall = 1'b1;
        // A read-valid arriving with the grant belongs to no access yet.
        if (dmem_gnt_i) begin
          if (r_we) begin
            w_stall     = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (dmem_rvalid_i) begin
          w_stall     = 1'b0;
          w_wb        = w_load_data;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs; stall/err derive from live inputs in ST_IDLE, so they are
  // masked directly while reset is held.
  // ---------------------------------------------------------------------------
  assign Mem_REn_o    = valid_i & Mem_REn_i;
  assign stall_o      = w_stall & ~rst_i;
  assign err_o        = w_err & ~rst_i;
  assign dmem_req_o   = w_req;
  assign dmem_we_o    = w_we;
  assign dmem_addr_o  = {r_addr[ADDR_WIDTH-1:3], 3'b000};
  assign dmem_wdata_o = r_wdata;
  assign dmem_wstrb_o = r_wstrb;
  assign WB_Data_o    = w_wb;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        Mem_REn_i;
  logic        Mem_WEn_i;
  logic [2:0]  funct3_i;
  logic [63:0] addr_i;
  logic [63:0] store_data_i;
  logic [63:0] alu_result_i;
  logic [63:0] WB_Data_o;
  logic        Mem_REn_o;
  logic        stall_o;
  logic        err_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;

  mem_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .Mem_REn_i    (Mem_REn_i),
    .Mem_WEn_i    (Mem_WEn_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .alu_result_i (alu_result_i),
    .WB_Data_o    (WB_Data_o),
    .Mem_REn_o    (Mem_REn_o),
    .stall_o      (stall_o),
    .err_o        (err_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_wstrb_o (dmem_wstrb_o),
    .dmem_gnt_i   (dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i (dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Per-cycle expectations, set by the stimulus process after each rising edge.
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_err, exp_mren, exp_we;
  logic        chk_bus, chk_wb, chk_rst;
  logic [63:0] exp_addr, exp_wdata, exp_wb;
  logic [7:0]  exp_wstrb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (transaction level)
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [63:0] a,
                                             input logic [2:0] f3);
    int          k;
    int          n;
    logic [63:0] mask;
    logic [63:0] v;
    k    = int'(a[2:0]);
    n    = 1 << f3[1:0];
    mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    v    = (rd >> (8 * k)) & mask;
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] sd, input logic [63:0] a);
    return sd << (8 * int'(a[2:0]));
  endfunction

  function automatic logic [7:0] model_wstrb(input logic [63:0] a, input logic [2:0] f3);
    logic [15:0] t;
    t = (16'd1 << (1 << f3[1:0])) - 16'd1;
    t = t << a[2:0];
    return t[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("stall", {63'd0, stall_o}, {63'd0, exp_stall});
      check("req",   {63'd0, dmem_req_o}, {63'd0, exp_req});
      check("err",   {63'd0, err_o}, {63'd0, exp_err});
      check("mren",  {63'd0, Mem_REn_o}, {63'd0, exp_mren});
      if (chk_bus) begin
        check("addr", dmem_addr_o, exp_addr);
        check("we",   {63'd0, dmem_we_o}, {63'd0, exp_we});
        if (exp_we) begin
          check("wdata", dmem_wdata_o, exp_wdata);
          check("wstrb", {56'd0, dmem_wstrb_o}, {56'd0, exp_wstrb});
        end
      end
      if (chk_wb) check("wb", WB_Data_o, exp_wb);
      if (chk_rst) begin
        check("rst_addr",  dmem_addr_o, 64'd0);
        check("rst_wdata", dmem_wdata_o, 64'd0);
        check("rst_wstrb", {56'd0, dmem_wstrb_o}, 64'd0);
        check("rst_we",    {63'd0, dmem_we_o}, 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One instruction: g = grant delay in REQ cycles, r = rvalid delay in WAIT
  // cycles, both = also pulse rvalid with the grant of a load.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input logic v, input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd, input logic [63:0] alu,
                         input int g, input int r, input logic both, input logic [63:0] rd,
                         input logic ovr, input logic [63:0] ovr_wb);
    logic is_mem;
    logic is_load;
    logic fault;
    int   n;
    @(posedge clk_i); #1;
    valid_i       = v;
    Mem_REn_i     = ren;
    Mem_WEn_i     = wen;
    funct3_i      = f3;
    addr_i        = a;
    store_data_i  = sd;
    alu_result_i  = alu;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = {$urandom, $urandom};
    is_mem  = v & (ren | wen);
    is_load = ren;
    n       = 1 << f3[1:0];
    fault   = (is_load ? (f3 == 3'b111) : f3[2]) || ((a % 64'(n)) != 64'd0);
    exp_mren = v & ren;
    chk_bus  = 1'b0;
    chk_rst  = 1'b0;
    exp_req  = 1'b0;
    if (!is_mem) begin
      exp_stall = 1'b0;
      exp_err   = 1'b0;
      chk_wb    = 1'b1;
      exp_wb    = alu;
    end else if (fault) begin
      exp_stall = 1'b0;
      exp_err   = 1'b1;
      chk_wb    = 1'b1;
      exp_wb    = 64'd0;
    end else begin
      exp_stall = 1'b1;
      exp_err   = 1'b0;
      chk_wb    = 1'b0;
      exp_addr  = a & ~64'h7;
      exp_we    = !is_load;
      exp_wdata = model_wdata(sd, a);
      exp_wstrb = model_wstrb(a, f3);
      for (int i = 0; i <= g; i++) begin
        @(posedge clk_i); #1;
        dmem_gnt_i    = (i == g);
        dmem_rvalid_i = (i == g) && both && is_load;
        dmem_rdata_i  = {$urandom, $urandom};
        exp_req       = 1'b1;
        chk_bus       = 1'b1;
        exp_stall     = !((i == g) && !is_load);
      end
      if (is_load) begin
        for (int j = 0; j <= r; j++) begin
          @(posedge clk_i); #1;
          chk_bus       = 1'b0;
          exp_req       = 1'b0;
          dmem_gnt_i    = 1'($urandom_range(0, 1));
          dmem_rvalid_i = (j == r);
          dmem_rdata_i  = (j == r) ? rd : {$urandom, $urandom};
          exp_stall     = (j != r);
          if (j == r) begin
            chk_wb = 1'b1;
            exp_wb = ovr ? ovr_wb : model_load(rd, a, f3);
          end
        end
      end
    end
  endtask

  // Load reaches WAIT, reset hits, then a stale rvalid arrives.
  task automatic reset_in_wait();
    @(posedge clk_i); #1;
    valid_i = 1'b1; Mem_REn_i = 1'b1; Mem_WEn_i = 1'b0; funct3_i = 3'b011;
    addr_i = 64'h3008; alu_result_i = 64'h77; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_mren = 1'b1;
    chk_bus = 1'b0; chk_wb = 1'b0; chk_rst = 1'b0;
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b1; exp_req = 1'b1; chk_bus = 1'b1; exp_addr = 64'h3008; exp_we = 1'b0;
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0; exp_req = 1'b0; chk_bus = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1; exp_stall = 1'b0; chk_rst = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; valid_i = 1'b0; Mem_REn_i = 1'b0; alu_result_i = 64'h5555;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
    exp_mren = 1'b0; chk_wb = 1'b1; exp_wb = 64'h5555;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0; chk_rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [63:0] a;
    int          kind;
    int          n;

    // Reset with a faulting load presented: everything must stay quiet.
    rst_i = 1'b1; valid_i = 1'b1; Mem_REn_i = 1'b1; Mem_WEn_i = 1'b0; funct3_i = 3'b010;
    addr_i = 64'h1002; store_data_i = 64'd0; alu_result_i = 64'd0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 64'd0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_mren = 1'b1; exp_we = 1'b0;
    exp_addr = 64'd0; exp_wdata = 64'd0; exp_wstrb = 8'd0; exp_wb = 64'd0;
    chk_bus = 1'b0; chk_wb = 1'b0; chk_rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0; valid_i = 1'b0; Mem_REn_i = 1'b0;
    exp_mren = 1'b0; chk_wb = 1'b1; exp_wb = 64'd0;

    // Pin the model with hand-computed values.
    check("pin_lb",       model_load(64'h0000_0000_8000_0000, 64'h1003, 3'b000), 64'hFFFF_FFFF_FFFF_FF80);
    check("pin_lwu",      model_load(64'hF000_0000_0000_0000, 64'h1004, 3'b110), 64'h0000_0000_F000_0000);
    check("pin_sh_wdata", model_wdata(64'hABCD, 64'h2006), 64'hABCD_0000_0000_0000);
    check("pin_sh_wstrb", {56'd0, model_wstrb(64'h2006, 3'b001)}, 64'h0000_0000_0000_00C0);

    // Directed cases with literal expectations.
    run_txn(1, 1, 0, 3'b000, 64'h1003, 64'd0, 64'd0, 0, 0, 0,
            64'h0000_0000_8000_0000, 1, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(1, 0, 1, 3'b001, 64'h2006, 64'hABCD, 64'd0, 2, 0, 0, 64'd0, 0, 64'd0);
    run_txn(1, 1, 0, 3'b010, 64'h1002, 64'd0, 64'h11, 0, 0, 0, 64'd0, 0, 64'd0);
    run_txn(1, 1, 0, 3'b111, 64'h1000, 64'd0, 64'h12, 0, 0, 0, 64'd0, 0, 64'd0);
    run_txn(1, 1, 0, 3'b110, 64'h1004, 64'd0, 64'd0, 0, 4, 0,
            64'hF000_0000_0000_0000, 1, 64'h0000_0000_F000_0000);
    run_txn(1, 0, 0, 3'b000, 64'h9, 64'd0, 64'h42, 0, 0, 0, 64'd0, 1, 64'h42);
    run_txn(0, 1, 0, 3'b011, 64'h8, 64'd0, 64'h99, 0, 0, 0, 64'd0, 0, 64'd0);
    run_txn(1, 1, 0, 3'b001, 64'h100E, 64'd0, 64'd0, 1, 1, 1,
            64'h8001_2345_6789_ABCD, 1, 64'hFFFF_FFFF_FFFF_8001);
    run_txn(1, 1, 1, 3'b100, 64'h2005, 64'hFF, 64'd0, 0, 1, 0,
            64'h0000_9A00_0000_0000, 1, 64'h0000_0000_0000_009A);
    run_txn(1, 0, 1, 3'b100, 64'h2000, 64'h1, 64'h13, 0, 0, 0, 64'd0, 0, 64'd0);
    run_txn(1, 0, 1, 3'b011, 64'h2004, 64'h1, 64'h14, 0, 0, 0, 64'd0, 0, 64'd0);
    reset_in_wait();
    run_txn(1, 0, 1, 3'b011, 64'h4000, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 0, 0, 64'd0, 0, 64'd0);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 9);
      a    = {$urandom, $urandom};
      if (kind >= 6 && kind <= 8) begin
        f3 = ($urandom_range(0, 9) == 0) ? {1'b1, 2'($urandom_range(0, 3))}
                                         : {1'b0, 2'($urandom_range(0, 3))};
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      n = 1 << f3[1:0];
      if ($urandom_range(0, 4) != 0) a = a & ~64'(n - 1);
      case (kind)
        0:       run_txn(1, 0, 0, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                         0, 0, 0, 64'd0, 0, 64'd0);
        1:       run_txn(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, a,
                         {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0, 64'd0, 0, 64'd0);
        6, 7, 8: run_txn(1, 0, 1, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                         $urandom_range(0, 3), 0, 0, 64'd0, 0, 64'd0);
        9:       run_txn(1, 1, 1, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                         $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                         {$urandom, $urandom}, 0, 64'd0);
        default: run_txn(1, 1, 0, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                         $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                         {$urandom, $urandom}, 0, 64'd0);
      endcase
    end

    @(posedge clk_i); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the data path and bus data width.
REQ-002 Parameter ADDR_WIDTH, default 64, SHALL set the address width.
REQ-003 clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 valid_i  in  1  SHALL mean the MEM-stage instruction is live.
REQ-006 Mem_REn_i / Mem_WEn_i  in  1 each  SHALL mean load / store; both high SHALL be treated as load.
REQ-007 funct3_i  in  3  SHALL give the RV64I size/sign code.
REQ-008 addr_i  in  ADDR_WIDTH  SHALL give the byte address from the ALU.
REQ-009 store_data_i  in  DATA_WIDTH  SHALL give the unshifted rs2 value.
REQ-010 alu_result_i  in  DATA_WIDTH  SHALL give the write-back value for non-memory ops.
REQ-011 WB_Data_o  out  DATA_WIDTH  SHALL give the write-back value that MEMWB captures.
REQ-012 Mem_REn_o  out  1  SHALL equal valid_i & Mem_REn_i.
REQ-013 stall_o  out  1  SHALL freeze upstream stages and hold MEMWB inputs while high.
REQ-014 err_o  out  1  SHALL flag a misaligned access or an illegal funct3.
REQ-015 dmem_req_o  out  1, dmem_we_o  out  1  SHALL form the bus request and its write flag.
REQ-016 dmem_addr_o  out  ADDR_WIDTH  SHALL be addr_i with bits [2:0] zeroed.
REQ-017 dmem_wdata_o  out  DATA_WIDTH, dmem_wstrb_o  out  8  SHALL give the lane-aligned store data and byte strobes.
REQ-018 dmem_gnt_i  in  1, dmem_rvalid_i  in  1, dmem_rdata_i  in  DATA_WIDTH  SHALL give grant, read-valid and read data.

Function
REQ-019 Loads: funct3 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; 111 SHALL be illegal.
REQ-020 Stores: funct3 000 SB, 001 SH, 010 SW, 011 SD; 1xx SHALL be illegal.
REQ-021 An access is misaligned when addr_i is not a multiple of 2/4/8 for the half/word/dword sizes.
REQ-022 An access is faulting when it is misaligned or uses an illegal funct3.
REQ-023 A faulting access SHALL drive err_o=1 combinationally, issue no bus request, leave stall_o=0, and drive WB_Data_o=0.
REQ-024 Non-memory ops and valid_i=0 SHALL pass through with zero latency: WB_Data_o=alu_result_i, stall_o=0, no request.
REQ-025 FSM states are IDLE, REQ and WAIT; the reset state is IDLE.
REQ-026 In IDLE, a valid non-faulting access SHALL latch addr/funct3/we/wdata/wstrb, move to REQ and drive stall_o=1 in that cycle.
REQ-027 In REQ, dmem_req_o SHALL be 1 with stable address, data, strobes and write flag until the cycle in which dmem_gnt_i=1.
REQ-028 In REQ, a grant on a store SHALL return to IDLE and drive stall_o=0 that cycle; a grant on a load SHALL move to WAIT.
REQ-029 In WAIT, dmem_req_o SHALL be 0; the FSM waits for dmem_rvalid_i, and dmem_gnt_i SHALL be ignored.
REQ-030 In WAIT with dmem_rvalid_i=1, stall_o SHALL be 0, WB_Data_o SHALL be the extracted and extended load data, and the FSM SHALL return to IDLE.
REQ-031 Otherwise stall_o SHALL be 1 in REQ and WAIT.
REQ-032 Minimum latency SHALL be 2 cycles for a store (grant in the first REQ cycle) and 3 cycles for a load (rvalid in the first WAIT cycle).
REQ-033 Store data SHALL be store_data_i shifted left by addr[2:0]*8; wstrb SHALL be 0x01/0x03/0x0F/0xFF shifted left by addr[2:0].
REQ-034 Load extraction SHALL shift dmem_rdata_i right by addr[2:0]*8, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to 64 bits; LD SHALL use the data unmodified.
REQ-035 Returning to IDLE SHALL NOT start a new access in the same cycle; the next access starts on the following cycle once the pipeline advances.
REQ-036 Upstream holds all inputs stable while stall_o=1; the block SHALL use only its latched copies after leaving IDLE.
REQ-037 The block SHALL accept dmem_gnt_i and dmem_rvalid_i in the same cycle for a load, then go REQ->WAIT only and complete on the next rvalid.

Reset
REQ-038 rst_i=1 SHALL immediately force IDLE and clear all latched request state, so dmem_req_o=0, dmem_we_o=0, dmem_wstrb_o=0, dmem_wdata_o=0, dmem_addr_o=0, stall_o=0 and err_o=0.
REQ-039 Reset during REQ or WAIT SHALL abandon the access, and a later dmem_rvalid_i SHALL be ignored.

Verification
REQ-040 LB at addr 0x1003 with rdata 0x00000000_80000000, grant and rvalid immediate -> stall 1,1,0 and WB_Data_o=0xFFFFFFFF_FFFFFF80 in cycle 3.
REQ-041 SH of 0xABCD at 0x2006 -> wdata=0xABCD0000_00000000, wstrb=0xC0, addr=0x2000, req held 3 cycles with gnt delayed 2 cycles, stall clears in the grant cycle.
REQ-042 LW at 0x1002 -> err_o=1, dmem_req_o=0, stall_o=0; a load with funct3=111 -> err_o=1.
REQ-043 LWU at 0x1004 with rdata 0xF0000000_00000000 and rvalid delayed 4 cycles -> stall stays high and WB_Data_o=0x00000000_F0000000.
REQ-044 Non-memory op with alu_result=0x42 -> WB_Data_o=0x42, stall 0, no request, in the same cycle.
REQ-045 rst_i asserted in WAIT followed by rvalid -> state IDLE, stall 0, no write-back data produced.
